multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//   Main control FSM of the multi-cycle CPU. Sequences every instruction through the fetch,
//   decode, execute, memory and writeback steps. Drives the write enables of the PC, IR and
//   register-file registers and the datapath mux selects.
//   Stalls on a memory ready handshake. Flags unsupported opcodes.
// PARAMETERS
//   OPW        6   opcode width (instr[31:26])
//   STW        4   state register width
// PORTS
//   clk          in   1   system clock, rising edge
//   rst          in   1   reset; one clock; reset is asynchronous and active-low
//   opcode       in   6   IR[31:26], valid from DECODE onward
//   mem_ready    in   1   memory completes the current access this cycle
//   zero         in   1   ALU zero flag, sampled in BRANCH
//   pcwrite      out  1   PC register write enable
//   irwrite      out  1   IR register write enable
//   regwrite     out  1   register-file write enable
//   memread      out  1   memory read strobe
//   memwrite     out  1   memory write strobe
//   iord         out  1   0 = address from PC, 1 = address from ALUOut
//   regdst       out  1   0 = rt, 1 = rd
//   memtoreg     out  1   0 = ALUOut, 1 = MDR
//   alusrca      out  1   0 = PC, 1 = A
//   alusrcb      out  2   00 = B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
//   aluop        out  2   00 = add, 01 = sub, 10 = funct-decoded
//   pcsource     out  2   00 = ALU result, 01 = ALUOut, 10 = jump target
//   instr_done   out  1   1-cycle pulse on the last cycle of each instruction
//   illegal_op   out  1   sticky flag; cleared only by reset
// BEHAVIOUR
//   - Reset (rst = 0, async): state = FETCH, illegal_op = 0. All enables and strobes are forced 0
//     while reset is held. The first fetch starts on the first clk after rst goes high.
//   - States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, ADDIEX, IWB, BRANCH, JUMP.
//   - FETCH: memread = 1, iord = 0, alusrca = 0, alusrcb = 01, aluop = 00, pcsource = 00.
//     Holds until mem_ready = 1. In that cycle irwrite = pcwrite = 1 and next state = DECODE.
//     irwrite and pcwrite are never 1 without mem_ready.
//   - DECODE: alusrca = 0, alusrcb = 11, aluop = 00 (branch target into ALUOut). Dispatch:
//     lw/sw (0x23/0x2B) -> MEMADR; R-type (0x00) -> EXEC; addi (0x08) -> ADDIEX;
//     beq (0x04) -> BRANCH; j (0x02) -> JUMP.
//     Any other opcode sets illegal_op, pulses instr_done and returns to FETCH.
//   - MEMADR: alusrca = 1, alusrcb = 10, aluop = 00. lw -> MEMRD, sw -> MEMWR.
//   - MEMRD: memread = 1, iord = 1; waits for mem_ready, then -> MEMWB.
//   - MEMWB: regwrite = 1, regdst = 0, memtoreg = 1, instr_done = 1 -> FETCH.
//   - MEMWR: memwrite = 1, iord = 1; waits for mem_ready.
//     instr_done = 1 in the mem_ready cycle -> FETCH.
//   - EXEC: alusrca = 1, alusrcb = 00, aluop = 10 -> RWB.
//   - RWB: regwrite = 1, regdst = 1, memtoreg = 0, instr_done = 1 -> FETCH.
//   - ADDIEX: alusrca = 1, alusrcb = 10, aluop = 00 -> IWB.
//   - IWB: regwrite = 1, regdst = 0, memtoreg = 0, instr_done = 1 -> FETCH.
//   - BRANCH: alusrca = 1, alusrcb = 00, aluop = 01, pcsource = 01, pcwrite = zero,
//     instr_done = 1 -> FETCH.
//   - JUMP: pcsource = 10, pcwrite = 1, instr_done = 1 -> FETCH.
//   - Latency with mem_ready tied high: lw 5 cycles; sw, R-type and addi 4; beq and j 3.
//     Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds 1 cycle.
//   - Outputs are decoded combinationally from the state register plus mem_ready and zero.
//     Any don't-care select is driven 0. At most one of memread and memwrite is 1 in any cycle.
//   - Unreachable state encodings go to FETCH on the next clk.
//   - mem_ready outside FETCH, MEMRD and MEMWR is ignored.
//   - Reset asserted mid-instruction aborts it: no write enable fires after the rst edge.
// STRUCTURE
//   - Shared package mc_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI),
//     state encodings, ALUOP_* and PCSRC_* / ALUSRCB_* codes.
//   - Single module: one state register process plus one combinational next-state/output block.
//     No sub-module.
// TESTING
//   - Reset: hold rst = 0 across 3 clks with mem_ready = 1 -> pcwrite = irwrite = regwrite = memwrite = 0,
//     illegal_op = 0. After release, FETCH with memread = 1.
//   - lw (0x23), mem_ready = 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB.
//     regwrite = 1 and memtoreg = 1 on cycle 5; instr_done pulses once.
//   - sw (0x2B) with mem_ready low for 2 cycles in MEMWR -> memwrite held 3 cycles, iord = 1,
//     regwrite never 1, total 6 cycles.
//   - beq (0x04), zero = 1 then zero = 0 -> pcwrite = 1 with pcsource = 01 in BRANCH on the first run only.
//     3 cycles each run.
//   - Opcode 0x3F -> illegal_op = 1 after DECODE, back in FETCH on the next clk. Flag persists until rst = 0.
//   - rst pulsed low during MEMRD of a lw -> state = FETCH, no regwrite for the aborted lw.

Source files
------------

// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - opcode, state and datapath select encodings for the multi-cycle control FSM
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_MEMADR = 4'd2;
  localparam logic [3:0] ST_MEMRD  = 4'd3;
  localparam logic [3:0] ST_MEMWB  = 4'd4;
  localparam logic [3:0] ST_MEMWR  = 4'd5;
  localparam logic [3:0] ST_EXEC   = 4'd6;
  localparam logic [3:0] ST_RWB    = 4'd7;
  localparam logic [3:0] ST_ADDIEX = 4'd8;
  localparam logic [3:0] ST_IWB    = 4'd9;
  localparam logic [3:0] ST_BRANCH = 4'd10;
  localparam logic [3:0] ST_JUMP   = 4'd11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B    = 2'b00;
  localparam logic [1:0] ALUSRCB_4    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM  = 2'b10;
  localparam logic [1:0] ALUSRCB_BOFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       irwrite;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - controller <-> datapath signal bundle
interface multicycle_ctrl_if #(
  parameter int OPW = 6
);
  logic [OPW-1:0] opcode;
  logic           mem_ready;
  logic           zero;
  logic           pcwrite;
  logic           irwrite;
  logic           regwrite;
  logic           memread;
  logic           memwrite;
  logic           iord;
  logic           regdst;
  logic           memtoreg;
  logic           alusrca;
  logic [1:0]     alusrcb;
  logic [1:0]     aluop;
  logic [1:0]     pcsource;
  logic           instr_done;
  logic           illegal_op;

  modport master (
    input  opcode, mem_ready, zero,
    output pcwrite, irwrite, regwrite, memread, memwrite, iord, regdst, memtoreg,
           alusrca, alusrcb, aluop, pcsource, instr_done, illegal_op
  );

  modport slave (
    output opcode, mem_ready, zero,
    input  pcwrite, irwrite, regwrite, memread, memwrite, iord, regdst, memtoreg,
           alusrca, alusrcb, aluop, pcsource, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - main control FSM of the multi-cycle CPU
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   bus
);

  logic [STW-1:0] state_q, state_d;
  logic           illegal_q, illegal_d;
  ctrl_t          c;

  always_comb begin
    c         = '0;
    state_d   = ST_FETCH;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH: begin
        c.memread = 1'b1;
        c.alusrcb = ALUSRCB_4;
        c.aluop   = ALUOP_ADD;
        c.pcsource = PCSRC_ALU;
        if (bus.mem_ready) begin
          c.irwrite = 1'b1;
          c.pcwrite = 1'b1;
          state_d   = ST_DECODE;
        end else begin
          state_d   = ST_FETCH;
        end
      end
      ST_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        c.alusrcb = ALUSRCB_BOFF;
        c.aluop   = ALUOP_ADD;
        case (bus.opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          default: begin
            illegal_d    = 1'b1;
            c.instr_done = 1'b1;
            state_d      = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_IMM;
        c.aluop   = ALUOP_ADD;
        state_d   = (bus.opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      end
      ST_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
        state_d   = bus.mem_ready ? ST_MEMWB : ST_MEMRD;
      end
      ST_MEMWB: begin
        c.regwrite   = 1'b1;
        c.memtoreg   = 1'b1;
        c.instr_done = 1'b1;
      end
      ST_MEMWR: begin
        c.memwrite   = 1'b1;
        c.iord       = 1'b1;
        c.instr_done = bus.mem_ready;
        state_d      = bus.mem_ready ? ST_FETCH : ST_MEMWR;
      end
      ST_EXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_B;
        c.aluop   = ALUOP_FUNCT;
        state_d   = ST_RWB;
      end
      ST_RWB: begin
        c.regwrite   = 1'b1;
        c.regdst     = 1'b1;
        c.instr_done = 1'b1;
      end
      ST_ADDIEX: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_IMM;
        c.aluop   = ALUOP_ADD;
        state_d   = ST_IWB;
      end
      ST_IWB: begin
        c.regwrite   = 1'b1;
        c.instr_done = 1'b1;
      end
      ST_BRANCH: begin
        c.alusrca    = 1'b1;
        c.alusrcb    = ALUSRCB_B;
        c.aluop      = ALUOP_SUB;
        c.pcsource   = PCSRC_ALUOUT;
        c.pcwrite    = bus.zero;
        c.instr_done = 1'b1;
      end
      ST_JUMP: begin
        c.pcsource   = PCSRC_JUMP;
        c.pcwrite    = 1'b1;
        c.instr_done = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Strobes are gated by reset so nothing writes while reset is low, even mid-instruction.
  assign bus.pcwrite    = c.pcwrite    & rst;
  assign bus.irwrite    = c.irwrite    & rst;
  assign bus.regwrite   = c.regwrite   & rst;
  assign bus.memread    = c.memread    & rst;
  assign bus.memwrite   = c.memwrite   & rst;
  assign bus.instr_done = c.instr_done & rst;
  assign bus.iord       = c.iord;
  assign bus.regdst     = c.regdst;
  assign bus.memtoreg   = c.memtoreg;
  assign bus.alusrca    = c.alusrca;
  assign bus.alusrcb    = c.alusrcb;
  assign bus.aluop      = c.aluop;
  assign bus.pcsource   = c.pcsource;
  assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   ncyc, done_at, ndone;
  logic ill_exp;
  logic [16:0] sb[$];

  always #5 clk = ~clk;

  multicycle_ctrl_if #(.OPW(6)) bus ();

  multicycle_ctrl #(.OPW(6), .STW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic legal(input logic [5:0] op);
    return (op == 6'h00) || (op == 6'h02) || (op == 6'h04) ||
           (op == 6'h08) || (op == 6'h23) || (op == 6'h2B);
  endfunction

  // {pcwrite,irwrite,regwrite,memread,memwrite,iord,regdst,memtoreg,alusrca,alusrcb,aluop,pcsource,instr_done,illegal_op}
  function automatic logic [16:0] model(input logic [3:0] st, input logic mr, input logic z,
                                        input logic [5:0] op, input logic il);
    logic pw, iw, rw, mrd, mwr, io, rd, m2r, sa, dn;
    logic [1:0] sb_, ao, ps;
    {pw, iw, rw, mrd, mwr, io, rd, m2r, sa, dn} = '0;
    sb_ = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      ST_FETCH:  begin mrd = 1; sb_ = 2'b01; pw = mr; iw = mr; end
      ST_DECODE: begin sb_ = 2'b11; dn = !legal(op); end
      ST_MEMADR: begin sa = 1; sb_ = 2'b10; end
      ST_MEMRD:  begin mrd = 1; io = 1; end
      ST_MEMWB:  begin rw = 1; m2r = 1; dn = 1; end
      ST_MEMWR:  begin mwr = 1; io = 1; dn = mr; end
      ST_EXEC:   begin sa = 1; ao = 2'b10; end
      ST_RWB:    begin rw = 1; rd = 1; dn = 1; end
      ST_ADDIEX: begin sa = 1; sb_ = 2'b10; end
      ST_IWB:    begin rw = 1; dn = 1; end
      ST_BRANCH: begin sa = 1; ao = 2'b01; ps = 2'b01; pw = z; dn = 1; end
      ST_JUMP:   begin ps = 2'b10; pw = 1; dn = 1; end
      default:   ;
    endcase
    return {pw, iw, rw, mrd, mwr, io, rd, m2r, sa, sb_, ao, ps, dn, il};
  endfunction

  function automatic logic [16:0] obs_vec();
    return {bus.pcwrite, bus.irwrite, bus.regwrite, bus.memread, bus.memwrite, bus.iord,
            bus.regdst, bus.memtoreg, bus.alusrca, bus.alusrcb, bus.aluop, bus.pcsource,
            bus.instr_done, bus.illegal_op};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic begin_instr(input logic [5:0] op);
    bus.opcode = op;
    ncyc = 0; done_at = 0; ndone = 0;
  endtask

  // Called just after a rising edge; drives inputs, predicts, checks on the falling edge.
  task automatic cyc(input logic [3:0] st, input logic mr, input logic z);
    logic [16:0] e, o;
    bus.mem_ready = mr;
    bus.zero      = z;
    sb.push_back(model(st, mr, z, bus.opcode, ill_exp));
    @(negedge clk);
    ncyc++;
    e = sb.pop_front();
    o = obs_vec();
    chk($sformatf("op%02h_st%0d_c%0d", bus.opcode, st, ncyc), {15'd0, o}, {15'd0, e});
    if (o[1]) begin done_at = ncyc; ndone++; end
    if (st == ST_DECODE && !legal(bus.opcode)) ill_exp = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; bus.opcode = 6'h00; bus.mem_ready = 1'b1; bus.zero = 1'b0; ill_exp = 1'b0;
    ncyc = 0; done_at = 0; ndone = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_strobes", {26'd0, bus.pcwrite, bus.irwrite, bus.regwrite, bus.memwrite,
                          bus.illegal_op, bus.instr_done}, 32'd0);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    cyc(ST_FETCH, 0, 0);

    begin_instr(6'h23);
    cyc(ST_FETCH, 1, 0); cyc(ST_DECODE, 1, 0); cyc(ST_MEMADR, 1, 0);
    cyc(ST_MEMRD, 1, 0); cyc(ST_MEMWB, 1, 0);
    chk("lw_latency", done_at, 5);
    chk("lw_done_count", ndone, 1);

    begin_instr(6'h2B);
    cyc(ST_FETCH, 1, 0); cyc(ST_DECODE, 0, 0); cyc(ST_MEMADR, 0, 0);
    cyc(ST_MEMWR, 0, 0); cyc(ST_MEMWR, 0, 0); cyc(ST_MEMWR, 1, 0);
    chk("sw_latency", done_at, 6);

    begin_instr(6'h04);
    cyc(ST_FETCH, 1, 1); cyc(ST_DECODE, 1, 1); cyc(ST_BRANCH, 1, 1);
    chk("beq_taken_latency", done_at, 3);
    begin_instr(6'h04);
    cyc(ST_FETCH, 1, 0); cyc(ST_DECODE, 1, 0); cyc(ST_BRANCH, 1, 0);
    chk("beq_nt_latency", done_at, 3);

    begin_instr(6'h00);
    cyc(ST_FETCH, 0, 0); cyc(ST_FETCH, 1, 0); cyc(ST_DECODE, 1, 0);
    cyc(ST_EXEC, 1, 0); cyc(ST_RWB, 1, 0);
    chk("rtype_latency", done_at, 5);

    begin_instr(6'h08);
    cyc(ST_FETCH, 1, 0); cyc(ST_DECODE, 1, 0); cyc(ST_ADDIEX, 1, 0); cyc(ST_IWB, 1, 0);
    chk("addi_latency", done_at, 4);

    begin_instr(6'h02);
    cyc(ST_FETCH, 1, 0); cyc(ST_DECODE, 1, 0); cyc(ST_JUMP, 1, 0);
    chk("j_latency", done_at, 3);

    begin_instr(6'h3F);
    cyc(ST_FETCH, 1, 0); cyc(ST_DECODE, 1, 0);
    chk("illegal_latency", done_at, 2);
    begin_instr(6'h02);
    cyc(ST_FETCH, 1, 0); cyc(ST_DECODE, 1, 0); cyc(ST_JUMP, 1, 0);
    chk("illegal_sticky", {31'd0, bus.illegal_op}, 32'd1);

    begin_instr(6'h23);
    cyc(ST_FETCH, 1, 0); cyc(ST_DECODE, 1, 0); cyc(ST_MEMADR, 1, 0);
    bus.mem_ready = 1'b1;
    rst = 1'b0;
    ill_exp = 1'b0;
    @(negedge clk);
    chk("abort_strobes", {26'd0, bus.regwrite, bus.memread, bus.pcwrite, bus.irwrite,
                          bus.memwrite, bus.instr_done}, 32'd0);
    chk("abort_illegal_clr", {31'd0, bus.illegal_op}, 32'd0);
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    cyc(ST_FETCH, 0, 0);
    begin_instr(6'h02);
    cyc(ST_FETCH, 1, 0); cyc(ST_DECODE, 1, 0); cyc(ST_JUMP, 1, 0);
    chk("post_abort_j_latency", done_at, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
